// File: rtl/forward_network_pkg.sv
// Shared types for the operand-forwarding network.
//   ForwardPort   : one producer stage {write, eval, addr, value}
//   ForwardResult : lookup outcome per operand {hit, resolved, value}
//   RegAddr       : register address (address 0 reads as constant zero)
//   FwdState      : per-operand capture state
// Struct field widths come from DATA_W / ADDR_W here; the top-level
// DATA_WIDTH / ADDR_WIDTH parameters must agree with them.
package defs;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] RegAddr;

  typedef struct packed {
    logic              write;
    logic              eval;
    RegAddr            addr;
    logic [DATA_W-1:0] value;
  } ForwardPort;

  typedef struct packed {
    logic              hit;
    logic              resolved;
    logic [DATA_W-1:0] value;
  } ForwardResult;

  typedef enum logic {IDLE = 1'b0, CAPTURED = 1'b1} FwdState;
endpackage

// File: rtl/forward_network_if.sv
// Bus bundle between the decode stage (master) and forward_network (slave).
//   hold, fwd_port, addr, regfile_value : decode -> network
//   operand, fwd_result, stall_req      : resolved operands and stall
//   stall_cycles, fwd_hits              : performance counters
interface forward_network_if
  import defs::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int NUM_OPERANDS = 2,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int ADDR_WIDTH   = ADDR_W
);
  logic                                     hold;
  ForwardPort   [NUM_PORTS-1:0]             fwd_port;
  logic         [NUM_OPERANDS-1:0][ADDR_WIDTH-1:0] addr;
  logic         [NUM_OPERANDS-1:0][DATA_WIDTH-1:0] regfile_value;
  logic         [NUM_OPERANDS-1:0][DATA_WIDTH-1:0] operand;
  ForwardResult [NUM_OPERANDS-1:0]          fwd_result;
  logic                                     stall_req;
  logic         [31:0]                      stall_cycles;
  logic         [31:0]                      fwd_hits;

  modport master (
    output hold, fwd_port, addr, regfile_value,
    input  operand, fwd_result, stall_req, stall_cycles, fwd_hits
  );

  modport slave (
    input  hold, fwd_port, addr, regfile_value,
    output operand, fwd_result, stall_req, stall_cycles, fwd_hits
  );
endinterface

// File: rtl/forward_network_operand.sv
// forward_operand: resolves one source operand.
//   clock, reset   : clock, synchronous active-high reset
//   hold           : decode stalled; a resolved forward is captured and kept
//   fwd_port       : forwarding ports, index 0 youngest / highest priority
//   addr, regfile_value : source address and register-file data
//   operand        : final operand value
//   fwd_result     : selected {hit, resolved, value}
//   stall          : hit on a producer that has not evaluated yet
//   hit            : selected hit (feeds the hit counter)
module forward_operand
  import defs::*;
#(
  parameter int NUM_PORTS = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        hold,
  input  ForwardPort [NUM_PORTS-1:0]  fwd_port,
  input  RegAddr                      addr,
  input  logic [DATA_W-1:0]           regfile_value,
  output logic [DATA_W-1:0]           operand,
  output ForwardResult                fwd_result,
  output logic                        stall,
  output logic                        hit
);
  FwdState           state, state_nxt;
  logic [DATA_W-1:0] cap_value;
  ForwardResult      live, sel;

  // Scan oldest to youngest so the lowest matching index overwrites last.
  always_comb begin
    live = '0;
    for (int p = NUM_PORTS - 1; p >= 0; p--) begin
      if (fwd_port[p].write && fwd_port[p].addr == addr && addr != '0) begin
        live.hit      = 1'b1;
        live.resolved = fwd_port[p].eval;
        live.value    = fwd_port[p].value;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (hold && live.hit && live.resolved) state_nxt = CAPTURED;
      CAPTURED: if (!hold) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cap_value <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == CAPTURED) cap_value <= live.value;
    end
  end

  // While reset is asserted the outputs fall back to the register file
  // immediately, not one cycle later.
  always_comb begin
    sel = live;
    if (reset)                  sel = '0;
    else if (state == CAPTURED) sel = '{hit: 1'b1, resolved: 1'b1, value: cap_value};
  end

  assign fwd_result = sel;
  assign operand    = sel.hit ? sel.value : regfile_value;
  assign stall      = sel.hit && !sel.resolved;
  assign hit        = sel.hit;
endmodule

// File: rtl/forward_network.sv
// forward_network: resolves NUM_OPERANDS source registers against NUM_PORTS
// prioritised forwarding ports, holding captured forwards across hold.
//   clock, reset : clock, synchronous active-high reset
//   bus          : forward_network_if.slave (hold, fwd_port, addr,
//                  regfile_value in; operand, fwd_result, stall_req,
//                  stall_cycles, fwd_hits out)
// Optional feature macro: FORWARD_PERF_EN enables the stall_cycles and
// fwd_hits counters; without it both outputs are constant zero.
module forward_network
  import defs::*;
#(
  parameter int NUM_PORTS    = 3,
  parameter int NUM_OPERANDS = 2,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int ADDR_WIDTH   = ADDR_W
) (
  input logic              clock,
  input logic              reset,
  forward_network_if.slave bus
);
  // Struct widths are fixed by the package.
  if (DATA_WIDTH != DATA_W || ADDR_WIDTH != ADDR_W) begin : g_width_check
    $error("forward_network: DATA_WIDTH/ADDR_WIDTH must match defs package");
  end

  logic         [NUM_OPERANDS-1:0][DATA_W-1:0] operand_w;
  ForwardResult [NUM_OPERANDS-1:0]             result_w;
  logic         [NUM_OPERANDS-1:0]             stall_vec;
  logic         [NUM_OPERANDS-1:0]             hit_vec;

  for (genvar o = 0; o < NUM_OPERANDS; o++) begin : g_op
    forward_operand #(.NUM_PORTS(NUM_PORTS)) u_op (
      .clock         (clock),
      .reset         (reset),
      .hold          (bus.hold),
      .fwd_port      (bus.fwd_port),
      .addr          (bus.addr[o]),
      .regfile_value (bus.regfile_value[o]),
      .operand       (operand_w[o]),
      .fwd_result    (result_w[o]),
      .stall         (stall_vec[o]),
      .hit           (hit_vec[o])
    );
  end

  assign bus.operand    = operand_w;
  assign bus.fwd_result = result_w;
  assign bus.stall_req  = |stall_vec;

`ifdef FORWARD_PERF_EN
  logic [31:0] stall_cycles_q, fwd_hits_q;

  // stall_req is already forced low during reset, so only non-reset
  // stall cycles are counted.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      fwd_hits_q     <= '0;
    end else begin
      if (bus.stall_req)             stall_cycles_q <= stall_cycles_q + 32'd1;
      if (!bus.hold && (|hit_vec))   fwd_hits_q     <= fwd_hits_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.fwd_hits     = fwd_hits_q;
`else
  assign bus.stall_cycles = '0;
  assign bus.fwd_hits     = '0;
`endif
endmodule

// File: doc/forward_network.md
# forward_network

Parametrised operand-forwarding network for the decode/issue stage. It resolves `NUM_OPERANDS` source registers against `NUM_PORTS` prioritised forwarding ports in one pass and raises a stall request when the newest matching producer has not yet evaluated its result. Per-operand capture registers keep a resolved forwarded value valid across a multi-cycle `hold`, so the operand survives even after its producer retires out of the forwarding window. It replaces the per-operand chain of single-port forward cells and separate preserver cells.

## Interface
Parameters:
- `NUM_PORTS`, 3: number of forwarding ports; index 0 is the youngest stage and has the highest priority.
- `NUM_OPERANDS`, 2: number of source operands resolved in parallel.
- `DATA_WIDTH`, 32: width of the register value.
- `ADDR_WIDTH`, 5: width of the register address; address 0 is hard-wired zero.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `hold`  in  1  decode stage stalled this cycle; `addr` and `regfile_value` are stable while it is high.
- `fwd_port`  in  NUM_PORTS x ForwardPort  per-stage {write, eval, addr, value}.
- `addr`  in  NUM_OPERANDS x ADDR_WIDTH  source register addresses.
- `regfile_value`  in  NUM_OPERANDS x DATA_WIDTH  register-file read data.
- `operand`  out  NUM_OPERANDS x DATA_WIDTH  resolved operand values.
- `fwd_result`  out  NUM_OPERANDS x ForwardResult  per operand {hit, resolved, value}.
- `stall_req`  out  1  at least one operand depends on an unevaluated producer.
- `stall_cycles`  out  32  performance counter; see Configuration.
- `fwd_hits`  out  32  performance counter; see Configuration.

## Operation
- Live match for port p and operand o: `fwd_port[p].write && fwd_port[p].addr == addr[o] && addr[o] != 0`. The lowest matching p wins.
- Live result: winner present gives {1, eval, value}; no winner gives {0, 0, 0}.
- Per-operand state machine with states IDLE and CAPTURED:
  - IDLE to CAPTURED: `hold` is high and the live result has hit=1 and resolved=1. Capture its value.
  - CAPTURED to IDLE: `hold` is low at the clock edge.
  - CAPTURED to CAPTURED: `hold` stays high. The captured value is frozen, and live ports are ignored even if an unresolved match appears.
- Output selection per operand:
  - In CAPTURED: {1, 1, captured value}.
  - Otherwise: the live result.
  - `operand` is the selected value when hit=1, else `regfile_value[o]`.
- `stall_req` is the OR over operands of (selected hit && !selected resolved).
- A `hold` with no resolved hit leaves the operand in IDLE. If the producer has retired, `regfile_value` is the correct source.
- Reset takes priority over `hold`. During reset:
  - all states go to IDLE and the captured values are cleared;
  - `stall_req` is forced to 0 and `operand` equals `regfile_value`.

## Timing
- Lookup to outputs is purely combinational, with zero-cycle latency.
- The capture takes effect on the edge where the entry condition is true. Outputs use the captured value from the next cycle onward.
- When `hold` falls, the register is released on that edge. The cycle after shows live results again.
- Reset values:
  - `stall_req` = 0;
  - `stall_cycles` = 0 and `fwd_hits` = 0;
  - `fwd_result` = {0, 0, 0};
  - `operand` = `regfile_value`.
- Simultaneous events:
  - Two ports match the same operand: the youngest wins, even when it is unresolved and an older port is resolved. The result is a stall.
  - The operands are independent. One operand may be CAPTURED while another stalls.

## Configuration
- `FORWARD_PERF_EN` defined:
  - `stall_cycles` increments on every non-reset cycle with `stall_req` = 1.
  - `fwd_hits` increments once per cycle in which `hold` = 0 and any operand's selected hit = 1.
  - Both counters are 32 bits and wrap from 0xFFFFFFFF to 0.
- `FORWARD_PERF_EN` undefined: no counter flops exist and both outputs are tied to 0.

## Structure
- Package `defs` holds:
  - `ForwardPort` {write, eval, addr, value};
  - `ForwardResult` {hit, resolved, value};
  - `RegAddr`;
  - a `FwdState` enum {IDLE, CAPTURED}.
- Sub-module `forward_operand` covers one operand: the priority lookup, the state machine and the capture register. The top level instantiates it `NUM_OPERANDS` times, then ORs the stall requests and adds the counters.

## Test plan
- Basic forwarding: port 1 = {write 1, eval 1, addr 5, value 0x1234} and `addr[0]` = 5 -> `operand[0]` = 0x1234 and `stall_req` = 0.
- Priority: port 0 = {1, 0, addr 5} and port 2 = {1, 1, addr 5, 0xAA} -> `stall_req` = 1 and `fwd_result[0]` = {1, 0, x}.
- Zero register: port 0 writes addr 0 with value 0xFF and `addr[0]` = 0 -> `operand[0]` = `regfile_value[0]` and `stall_req` = 0.
- Capture across hold:
  - Stimulus: `hold` = 1 for 3 cycles; port 1 resolves addr 7 = 0xBEEF in cycle 0, and the port drops in cycle 1.
  - Response: `operand[0]` = 0xBEEF in all 3 cycles, then back to live results after `hold` falls.
- Reset mid-hold: in CAPTURED, assert `reset` -> the next cycle is IDLE, and `operand` equals `regfile_value`.
- Counters with `FORWARD_PERF_EN`: 4 stall cycles -> `stall_cycles` = 4. Preload near wrap -> wraps to 0.
